// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: digit width, segment
// patterns (bit order a..g,dp with a in the MSB) and the dp bit position.
package seg7_pkg;

  localparam int BCD_W      = 4;
  localparam int SEG_W      = 8;
  localparam int SEG_DP_BIT = 0;

  localparam logic [SEG_W-1:0] SEG7_0     = 8'b11111100;
  localparam logic [SEG_W-1:0] SEG7_1     = 8'b01100000;
  localparam logic [SEG_W-1:0] SEG7_2     = 8'b11011010;
  localparam logic [SEG_W-1:0] SEG7_3     = 8'b11110010;
  localparam logic [SEG_W-1:0] SEG7_4     = 8'b01100110;
  localparam logic [SEG_W-1:0] SEG7_5     = 8'b10110110;
  localparam logic [SEG_W-1:0] SEG7_6     = 8'b10111110;
  localparam logic [SEG_W-1:0] SEG7_7     = 8'b11100000;
  localparam logic [SEG_W-1:0] SEG7_8     = 8'b11111110;
  localparam logic [SEG_W-1:0] SEG7_9     = 8'b11100110;
  localparam logic [SEG_W-1:0] SEG7_BLANK = 8'b00000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern decoder with a blanking input.
// Codes above 9 decode as blank; the decimal point is always off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG7_0;
        4'd1:    seg = SEG7_1;
        4'd2:    seg = SEG7_2;
        4'd3:    seg = SEG7_3;
        4'd4:    seg = SEG7_4;
        4'd5:    seg = SEG7_5;
        4'd6:    seg = SEG7_6;
        4'd7:    seg = SEG7_7;
        4'd8:    seg = SEG7_8;
        4'd9:    seg = SEG7_9;
        default: seg = SEG7_BLANK;
      endcase
    end
    seg[SEG_DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg7_counter_multi.sv
// Multi-digit BCD up/down counter with tick prescaler, programmable wrap,
// checked parallel load, leading-zero blanking and registered segment outputs.
module seg7_counter_multi
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 3,
  parameter int TICK_DIV  = 4,
  parameter int MAX_VALUE = 999
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [BCD_W*N_DIGITS-1:0] load_val,
  input  logic                      blank_lz,
  output logic [BCD_W*N_DIGITS-1:0] count_bcd,
  output logic [SEG_W*N_DIGITS-1:0] seg,
  output logic                      wrap,
  output logic                      load_err
);

  localparam int CW = BCD_W * N_DIGITS;
  localparam int SW = SEG_W * N_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  function automatic logic [CW-1:0] to_bcd(input int value);
    int v;
    v = value;
    to_bcd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      to_bcd[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (bcd_inc[BCD_W*i +: BCD_W] == 4'd9) begin
          bcd_inc[BCD_W*i +: BCD_W] = 4'd0;
        end else begin
          bcd_inc[BCD_W*i +: BCD_W] = bcd_inc[BCD_W*i +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic borrow;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (borrow) begin
        if (bcd_dec[BCD_W*i +: BCD_W] == 4'd0) begin
          bcd_dec[BCD_W*i +: BCD_W] = 4'd9;
        end else begin
          bcd_dec[BCD_W*i +: BCD_W] = bcd_dec[BCD_W*i +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic digits_valid(input logic [CW-1:0] v);
    digits_valid = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[BCD_W*i +: BCD_W] > 4'd9) digits_valid = 1'b0;
    end
  endfunction

  logic [PW-1:0] presc_p1;
  logic          step_p0;
  logic          load_ok_p0;
  logic [CW-1:0] count_p1;
  logic          wrap_p1;
  logic          load_err_p1;
  logic [N_DIGITS-1:0] blank_p1;
  logic [SW-1:0] seg_dec_p1;
  logic [SW-1:0] seg_p2;

  // p0: step and load qualification from inputs and current state
  assign step_p0 = en && (presc_p1 == PRESC_LAST);
  // With all digits valid, BCD ordering matches decimal ordering.
  assign load_ok_p0 = digits_valid(load_val) && (load_val <= MAX_BCD);

  // p1: count, prescaler and event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_p1    <= '0;
      presc_p1    <= '0;
      wrap_p1     <= 1'b0;
      load_err_p1 <= 1'b0;
    end else begin
      wrap_p1     <= 1'b0;
      load_err_p1 <= 1'b0;
      if (load) begin
        if (load_ok_p0) begin
          count_p1 <= load_val;
          presc_p1 <= '0;
        end else begin
          load_err_p1 <= 1'b1;
        end
      end else if (en) begin
        if (step_p0) begin
          presc_p1 <= '0;
          if (up_dn) begin
            if (count_p1 == MAX_BCD) begin
              count_p1 <= '0;
              wrap_p1  <= 1'b1;
            end else begin
              count_p1 <= bcd_inc(count_p1);
            end
          end else begin
            if (count_p1 == '0) begin
              count_p1 <= MAX_BCD;
              wrap_p1  <= 1'b1;
            end else begin
              count_p1 <= bcd_dec(count_p1);
            end
          end
        end else begin
          presc_p1 <= presc_p1 + PW'(1);
        end
      end
    end
  end

  always_comb begin
    logic seen;
    seen     = 1'b0;
    blank_p1 = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (count_p1[BCD_W*i +: BCD_W] != 4'd0) seen = 1'b1;
      blank_p1[i] = blank_lz && !seen;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd   (count_p1[BCD_W*g +: BCD_W]),
      .blank (blank_p1[g]),
      .seg   (seg_dec_p1[SEG_W*g +: SEG_W])
    );
  end

  // p2: registered segment patterns
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_p2 <= {N_DIGITS{SEG7_0}};
    end else begin
      seg_p2 <= seg_dec_p1;
    end
  end

  assign count_bcd = count_p1;
  assign wrap      = wrap_p1;
  assign load_err  = load_err_p1;
  assign seg       = seg_p2;

endmodule

// File: doc/seg7_counter_multi.md
Name: seg7_counter_multi

Overview:
Parametrised multi-digit BCD counter with registered 7-segment outputs. It generalises the single-digit 0-9 display counter to N cascaded digits and adds:
- a tick prescaler
- up/down counting
- a programmable wrap value
- parallel BCD load with validity check
- leading-zero blanking
- a wrap pulse

It sits between the timebase and the board's segment drivers. The wrap pulse lets instances be chained, e.g. seconds into minutes.

Parameters:
N_DIGITS, 3, number of BCD digits; legal 1..8.
TICK_DIV, 4, enabled clk cycles per count step; legal 1..2^16. With 1, the count steps every enabled cycle.
MAX_VALUE, 999, decimal wrap value; must be <= 10^N_DIGITS - 1.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low; sampled on rising clk.
en  in  1  count enable; gates the prescaler.
up_dn  in  1  1 = count up, 0 = count down; sampled at the step.
load  in  1  parallel load strobe, 1 cycle.
load_val  in  4*N_DIGITS  BCD load value, digit 0 in bits [3:0].
blank_lz  in  1  1 = blank leading zero digits.
count_bcd  out  4*N_DIGITS  current count, BCD, registered.
seg  out  8*N_DIGITS  segment patterns, digit 0 in [7:0]. Bit order a,b,c,d,e,f,g,dp, MSB = a.
wrap  out  1  1-cycle pulse on wrap, in either direction.
load_err  out  1  1-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=0 at a rising edge):
  - count_bcd=0, prescaler=0, wrap=0, load_err=0.
  - seg = 8'b11111100 in every digit, regardless of blank_lz.
  - Reset wins over every other input, including mid-load and mid-step.
- Prescaler:
  - When en=1, it counts 0..TICK_DIV-1.
  - The cycle it equals TICK_DIV-1 is a step cycle; the prescaler returns to 0 on that cycle.
  - When en=0, the prescaler holds and no step occurs.
- Priority per cycle: reset > load > step.
- Load (load=1):
  - If every digit of load_val is <= 9 and the value is <= MAX_VALUE, then count_bcd <= load_val and prescaler <= 0.
  - Otherwise count_bcd and prescaler are unchanged, and load_err=1 on the next cycle.
  - A step coinciding with a load is discarded.
  - wrap is never asserted by a load.
- Step up:
  - If count == MAX_VALUE, count <= 0 and wrap=1 for exactly one cycle, coincident with count_bcd updating.
  - Otherwise count increments by 1 with BCD ripple carry: a digit at 9 becomes 0 and carries into the next digit.
- Step down:
  - If count == 0, count <= MAX_VALUE and wrap=1 for one cycle.
  - Otherwise count decrements by 1 with BCD borrow: a digit at 0 becomes 9 and borrows from the next digit.
- Latency:
  - count_bcd changes 1 cycle after the step or load cycle.
  - seg reflects count_bcd 1 cycle later (seg is registered from count_bcd).
  - Total latency from step cycle to seg is 2 cycles.
- Segment encoding per digit, dp always 0:
  - 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110
  - 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11100110
  - Any code >9 = 00000000; unreachable under the load check, but still decoded as blank.
- Leading-zero blanking:
  - With blank_lz=1, every zero digit above the most significant non-zero digit shows 00000000.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - blank_lz is applied in the seg register stage, so it takes effect with 1-cycle latency.
- Arithmetic is purely BCD. No binary counter is kept, and no digit ever holds a value >9.

Decomposition:
- Shared package seg7_pkg holds:
  - segment pattern constants SEG7_0..SEG7_9 and SEG7_BLANK
  - a BCD digit width constant (4)
  - the dp bit index
- Sub-module seg7_decode: combinational, 4-bit BCD in, 8-bit pattern out, blanking input. Instantiated N_DIGITS times in a generate loop.
- The counter, prescaler, load check and leading-zero logic stay in seg7_counter_multi.

Test Plan:
1. Reset hold: rst=0 for 3 cycles with en=1 and load=1 -> count_bcd=0x000, seg=0xFCFCFC, wrap=0 and load_err=0 throughout.
2. Up count (defaults, en=1, up_dn=1) -> count_bcd steps every 4 cycles: 000, 001, ..., 009, 010. At each step seg lags count_bcd by exactly 1 cycle; digit 1 reads 0x60 after 009→010.
3. Wrap: load 0x999, up_dn=1 -> next step gives count_bcd=0x000 with a single-cycle wrap=1. Then up_dn=0 -> next step gives 0x999 with wrap=1.
4. Invalid load: load_val=0x9A2 -> count unchanged and load_err=1 for one cycle. Repeat with MAX_VALUE=59, N_DIGITS=2, load_val=0x60 -> also rejected.
5. Load vs step: load=1 with load_val=0x123 on a step cycle -> count_bcd=0x123 and the prescaler restarts, so the next step comes 4 enabled cycles later (0x124).
6. Blanking: count 0x007 with blank_lz=1 -> seg=0x0000E0. Count 0x000 -> seg=0x0000FC. Count 0x100 with blank_lz=0 -> seg=0x60FCFC. en=0 for 10 cycles -> count frozen.
